// File: rtl/mux_tree_pkg.sv
// ============================================================================
// Module   : mux_tree_pkg
// Brief    : Shared sizing helpers for the ccff-configured routing mux tree.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_tree_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // The enable bit sits directly above the select field in {enable, sel}.
  function automatic int cfg_enable_bit(input int num_in);
    return clog2(num_in);
  endfunction

  // Configuration word width, also used by the bitstream generator.
  function automatic int cfg_w(input int num_in);
    return clog2(num_in) + 1;
  endfunction

  // Reference build size.
  localparam int DEFAULT_NUM_IN     = 4;
  localparam int CFG_ENABLE_BIT     = cfg_enable_bit(DEFAULT_NUM_IN);
  localparam int DEFAULT_CFG_W      = cfg_w(DEFAULT_NUM_IN);

endpackage : mux_tree_pkg

`default_nettype wire

// File: rtl/mux_tree_ccff_chain.sv
// ============================================================================
// Module   : mux_tree_ccff_chain
// Brief    : Configuration shift chain with length-checked commit into the
//            active configuration register. MUX_TREE_CCFF_PARITY_EN appends
//            an odd-parity LSB to the chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_tree_ccff_chain
  import mux_tree_pkg::*;
#(
  parameter int CFG_W = DEFAULT_CFG_W
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             ccff_head,
  input  logic             shift_en,
  input  logic             commit,
  output logic             ccff_tail,
  output logic [CFG_W-1:0] act,
  output logic             cfg_valid,
  output logic             cfg_err
);

`ifdef MUX_TREE_CCFF_PARITY_EN
  localparam int CHAIN_W = CFG_W + 1;
`else
  localparam int CHAIN_W = CFG_W;
`endif
  localparam int             CNT_W    = clog2(CHAIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_W);

  logic [CHAIN_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   act_q, act_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               cfg_err_q, cfg_err_d;

  logic full;
  logic parity_ok;
  logic accept;

  always_comb begin
    full = (cnt_q == CNT_FULL);
`ifdef MUX_TREE_CCFF_PARITY_EN
    parity_ok = ^sr_q;
`else
    parity_ok = 1'b1;
`endif
    accept = commit && full && parity_ok;
  end

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {sr_q[CHAIN_W-2:0], ccff_head};
    end
  end

  // A commit always restarts the count; a shift in the same cycle is its first bit.
  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = shift_en ? CNT_W'(1) : '0;
    end else if (shift_en && !full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    act_d       = act_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    if (accept) begin
      act_d       = sr_q[CHAIN_W-1 -: CFG_W];
      cfg_valid_d = 1'b1;
    end
    if (commit) begin
      cfg_err_d = !accept;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ccff_tail = sr_q[CHAIN_W-1];
  assign act       = act_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule : mux_tree_ccff_chain

`default_nettype wire

// File: rtl/mux_tree_ccff.sv
// ============================================================================
// Module   : mux_tree_ccff
// Brief    : NUM_IN:1 routing mux with ccff-loaded, double-buffered config.
//            Optional chain parity via MUX_TREE_CCFF_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_tree_ccff
  import mux_tree_pkg::*;
#(
  parameter int   NUM_IN    = DEFAULT_NUM_IN,
  parameter logic CONST_VAL = 1'b1
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic [NUM_IN-1:0] in,
  input  logic              ccff_head,
  input  logic              shift_en,
  input  logic              commit,
  output logic              ccff_tail,
  output logic              out,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int SEL_W  = clog2(NUM_IN);
  localparam int CFG_W  = cfg_w(NUM_IN);
  localparam int EN_BIT = cfg_enable_bit(NUM_IN);
  localparam int LEAVES = 1 << SEL_W;

  logic [CFG_W-1:0] act;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             in_range;

  mux_tree_ccff_chain #(
    .CFG_W (CFG_W)
  ) u_chain (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .commit    (commit),
    .ccff_tail (ccff_tail),
    .act       (act),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  assign sel      = act[SEL_W-1:0];
  assign en       = act[EN_BIT];
  assign in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));

  // Binary heap of MUX2 nodes: heap node k lives at node[k-1], leaf j at heap LEAVES+j.
  logic [2*LEAVES-2:0] node;

  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < NUM_IN) begin : g_in
      assign node[LEAVES-1+j] = in[j];
    end else begin : g_pad
      assign node[LEAVES-1+j] = CONST_VAL;
    end
  end

  for (genvar d = 0; d < SEL_W; d++) begin : g_level
    for (genvar i = 0; i < (1 << d); i++) begin : g_mux2
      localparam int K = (1 << d) + i;
      assign node[K-1] = sel[SEL_W-1-d] ? node[2*K] : node[2*K-1];
    end
  end

  assign out = (en && in_range) ? node[0] : CONST_VAL;

endmodule : mux_tree_ccff

`default_nettype wire

// File: tb/tb_mux_tree_ccff.sv
// ============================================================================
// Module   : tb_mux_tree_ccff
// Brief    : Directed plus random scoreboard bench for mux_tree_ccff (NUM_IN=4).
//            Parity scenarios run when MUX_TREE_CCFF_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_tree_ccff;

`ifdef MUX_TREE_CCFF_PARITY_EN
  localparam int CH = 4;
`else
  localparam int CH = 3;
`endif

  logic       prog_clk;
  logic       pReset_n;
  logic [3:0] in;
  logic       ccff_head;
  logic       shift_en;
  logic       commit;
  logic       ccff_tail;
  logic       out;
  logic       cfg_valid;
  logic       cfg_err;

  mux_tree_ccff #(
    .NUM_IN    (4),
    .CONST_VAL (1'b1)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .in        (in),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .commit    (commit),
    .ccff_tail (ccff_tail),
    .out       (out),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    string tag;
    logic  out;
    logic  valid;
    logic  err;
    logic  tail;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic [CH-1:0] m_sr;
  int            m_cnt;
  logic [2:0]    m_act;
  logic          m_valid;
  logic          m_err;

  task automatic model_reset();
    m_sr    = '0;
    m_cnt   = 0;
    m_act   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic sh, input logic cm);
    logic ok;
    ok = (m_cnt == CH);
`ifdef MUX_TREE_CCFF_PARITY_EN
    ok = ok && (^m_sr);
`endif
    if (cm) begin
      if (ok) begin
        m_act   = m_sr[CH-1 -: 3];
        m_valid = 1'b1;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_cnt = sh ? 1 : 0;
    end else if (sh && m_cnt != CH) begin
      m_cnt = m_cnt + 1;
    end
    if (sh) m_sr = {m_sr[CH-2:0], h};
  endtask

  function automatic logic model_out();
    logic [1:0] s;
    s = m_act[1:0];
    if (!m_act[2]) return 1'b1;
    return in[s];
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag   = tag;
    e.out   = model_out();
    e.valid = m_valid;
    e.err   = m_err;
    e.tail  = m_sr[CH-1];
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %b expected %b", tag, field, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, "out",       out,       e.out);
    chk(e.tag, "cfg_valid", cfg_valid, e.valid);
    chk(e.tag, "cfg_err",   cfg_err,   e.err);
    chk(e.tag, "ccff_tail", ccff_tail, e.tail);
  endtask

  task automatic cycle(input logic h, input logic sh, input logic cm, input string tag);
    @(negedge prog_clk);
    ccff_head = h;
    shift_en  = sh;
    commit    = cm;
    model_step(h, sh, cm);
    push_exp(tag);
    @(posedge prog_clk);
    #1;
    pop_check();
    shift_en = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic check_now(input string tag);
    #1;
    push_exp(tag);
    pop_check();
  endtask

  task automatic shift3(input logic b2, input logic b1, input logic b0, input string tag);
    cycle(b2, 1'b1, 1'b0, tag);
    cycle(b1, 1'b1, 1'b0, tag);
    cycle(b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    pReset_n  = 1'b0;
    in        = 4'b0000;
    ccff_head = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    model_reset();
    repeat (2) @(negedge prog_clk);
    check_now("reset");
    chk("reset", "out_const", out, 1'b1);
    chk("reset", "tail_const", ccff_tail, 1'b0);
    @(negedge prog_clk);
    pReset_n = 1'b1;

`ifndef MUX_TREE_CCFF_PARITY_EN
    in = 4'b0100;
    shift3(1'b1, 1'b1, 1'b0, "load110");
    cycle(1'b0, 1'b0, 1'b1, "commit110");
    chk("commit110", "valid_const", cfg_valid, 1'b1);
    chk("commit110", "out_const", out, 1'b1);
    in = 4'b0000;
    check_now("toggle_in2_lo");
    chk("toggle_in2_lo", "out_const", out, 1'b0);
    in = 4'b0100;
    check_now("toggle_in2_hi");

    cycle(1'b1, 1'b1, 1'b0, "short");
    cycle(1'b0, 1'b1, 1'b0, "short");
    cycle(1'b0, 1'b0, 1'b1, "short_commit");
    chk("short_commit", "err_const", cfg_err, 1'b1);
    chk("short_commit", "out_const", out, 1'b1);

    shift3(1'b1, 1'b0, 1'b1, "load101");
    cycle(1'b0, 1'b1, 1'b1, "commit_shift");
    chk("commit_shift", "err_const", cfg_err, 1'b0);
    in = 4'b0010;
    check_now("sel1_hi");
    chk("sel1_hi", "out_const", out, 1'b1);
    in = 4'b1101;
    check_now("sel1_lo");
    chk("sel1_lo", "out_const", out, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, "cnt1_fill");
    cycle(1'b1, 1'b1, 1'b0, "cnt1_fill");
    cycle(1'b0, 1'b0, 1'b1, "cnt1_commit");
    chk("cnt1_commit", "err_const", cfg_err, 1'b0);

    shift3(1'b0, 1'b1, 1'b1, "load011");
    cycle(1'b0, 1'b0, 1'b1, "commit011");
    in = 4'b1111;
    check_now("disabled_1111");
    chk("disabled_1111", "out_const", out, 1'b1);
    in = 4'b0000;
    check_now("disabled_0000");
    chk("disabled_0000", "tail_const", ccff_tail, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, "tail_a");
    chk("tail_a", "tail_const", ccff_tail, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, "tail_b");
    chk("tail_b", "tail_const", ccff_tail, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, "tail_c");

    // Over-long load: the last three bits win and the saturated count still accepts.
    in = 4'b1000;
    cycle(1'b0, 1'b1, 1'b0, "sat");
    cycle(1'b0, 1'b1, 1'b0, "sat");
    shift3(1'b1, 1'b1, 1'b1, "sat");
    cycle(1'b0, 1'b0, 1'b1, "sat_commit");
    chk("sat_commit", "out_const", out, 1'b1);

    shift3(1'b1, 1'b0, 1'b0, "hold");
    cycle(1'b0, 1'b0, 1'b1, "hold_first");
    cycle(1'b0, 1'b0, 1'b1, "hold_second");
    chk("hold_second", "err_const", cfg_err, 1'b1);
    chk("hold_second", "valid_const", cfg_valid, 1'b1);
`else
    in = 4'b0100;
    cycle(1'b1, 1'b1, 1'b0, "par_ok");
    shift3(1'b1, 1'b0, 1'b1, "par_ok");
    cycle(1'b0, 1'b0, 1'b1, "par_ok_commit");
    chk("par_ok_commit", "valid_const", cfg_valid, 1'b1);
    chk("par_ok_commit", "err_const", cfg_err, 1'b0);
    chk("par_ok_commit", "out_const", out, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, "par_bad");
    shift3(1'b1, 1'b0, 1'b0, "par_bad");
    cycle(1'b0, 1'b0, 1'b1, "par_bad_commit");
    chk("par_bad_commit", "err_const", cfg_err, 1'b1);
    in = 4'b0000;
    check_now("par_bad_act_kept");
    chk("par_bad_act_kept", "out_const", out, 1'b0);
`endif

    // Asynchronous reset in the middle of a shift.
    @(negedge prog_clk);
    ccff_head = 1'b1;
    shift_en  = 1'b1;
    #2;
    pReset_n = 1'b0;
    model_reset();
    check_now("rst_mid_shift");
    chk("rst_mid_shift", "valid_const", cfg_valid, 1'b0);
    shift_en = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;

    for (int k = 0; k < 80; k++) begin
      in = 4'($urandom);
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), "random");
    end

    // Asynchronous reset on a commit cycle.
    @(negedge prog_clk);
    commit = 1'b1;
    #2;
    pReset_n = 1'b0;
    model_reset();
    check_now("rst_commit");
    commit = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;
    check_now("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mux_tree_ccff

`default_nettype wire

// File: doc/mux_tree_ccff.md
# mux_tree_ccff

Parametrised successor to the fixed two-input routing mux tree. It selects one of `NUM_IN` routing inputs, or a constant, using configuration bits. The bits are loaded through an integrated configuration shift chain (ccff) and applied only on an explicit, length-checked commit. It sits in connection and switch blocks wherever the fabric needs an N:1 routing mux with a safe default state and double-buffered configuration.

## Interface
Parameters:
- `NUM_IN`, default 4: number of routing inputs; legal range is 2 to 64.
- `CONST_VAL`, default 1'b1: value driven on `out` when the mux is disabled or the select is out of range.
- `SEL_W`, derived as clog2(`NUM_IN`): select field width. It is not overridable.
- `CFG_W`, derived as `SEL_W`+1: configuration word width, {enable, sel}.

Ports:
- `prog_clk`, input, 1: configuration clock; the only clock.
- `pReset_n`, input, 1: reset, asynchronous, active-low.
- `in`, input, `NUM_IN`: routing inputs.
- `ccff_head`, input, 1: serial configuration input.
- `shift_en`, input, 1: when high, shift the chain by one bit per `prog_clk` edge.
- `commit`, input, 1: single-cycle request to copy the shift register into the active configuration.
- `ccff_tail`, output, 1: serial output to the next ccff in the chain.
- `out`, output, 1: mux output.
- `cfg_valid`, output, 1: at least one commit has been accepted since reset.
- `cfg_err`, output, 1: sticky flag; the last commit was rejected.

## Operation
- Shift register `sr[CFG_W-1:0]`: on each `shift_en` edge, `sr <= {sr[CFG_W-2:0], ccff_head}`. The first bit shifted in ends up in the MSB, which is the enable bit.
- `ccff_tail` = `sr[CFG_W-1]`, taken straight from the register with no logic.
- Shift counter `cnt`:
  - Increments on each shift and saturates at `CFG_W`.
  - Once saturated, further shifts keep `cnt` at `CFG_W`. The chain is still valid in pass-through use.
- Commit accepted (`commit` high and `cnt == CFG_W`):
  - `act <= sr`, `cnt <= 0`, `cfg_valid <= 1`, `cfg_err <= 0`.
- Commit rejected (`cnt != CFG_W`):
  - `act` is unchanged, `cfg_err <= 1`, `cnt <= 0`.
- Commit and shift in the same cycle:
  - The commit samples `sr` before the shift.
  - The shift still occurs, and `cnt` ends at 1.
- Output, combinational from `act`:
  - `act[SEL_W] == 0`: `out = CONST_VAL`.
  - Otherwise `out = in[act[SEL_W-1:0]]`.
  - Select index ≥ `NUM_IN`: `out = CONST_VAL`.
- Reset (asserted any time, including mid-shift or on a commit cycle): `sr`, `act`, and `cnt` clear to 0.

## Timing
- Reset values: `ccff_tail` 0, `out` = `CONST_VAL`, `cfg_valid` 0, `cfg_err` 0.
- Latency from `ccff_head` to `ccff_tail` is `CFG_W` shift cycles.
- `out` reflects a new configuration combinationally after the accepting `prog_clk` edge; there is no glitch before that edge.
- `out` follows `in` combinationally, with zero cycles of latency.
- `commit` is level-sampled on each edge. Holding it high for two cycles means the second sample sees `cnt == 0` and is rejected.

## Configuration
- Macro `MUX_TREE_CCFF_PARITY_EN`.
- Defined:
  - The chain gains one odd-parity bit as the LSB, so chain length is `CFG_W+1`.
  - A commit is accepted only if `cnt == CFG_W+1` and parity over all `CFG_W+1` bits is odd.
  - A parity failure is rejected exactly like a count failure.
  - The parity bit is not stored in `act`.
- Undefined:
  - The chain is `CFG_W` bits and the count check alone gates a commit.

## Structure
- Package `mux_tree_pkg` contains:
  - the clog2 function;
  - the `CFG_ENABLE_BIT` index constant;
  - the `CFG_W` computation, shared with the fabric bitstream tooling.
- Sub-module `mux_tree_ccff_chain` holds `sr`, `cnt`, the parity check, and the accept/reject logic. It outputs `act`, `cfg_valid`, `cfg_err`, and `ccff_tail`.
- The top level instantiates the chain and a `MUX2` tree of depth `SEL_W`, plus a final enable/range stage that chooses `CONST_VAL`.

## Test plan
All scenarios use `NUM_IN`=4, so `CFG_W`=3.
- Reset, then `in`=4'b0000 → `out`=1, `cfg_valid`=0, `cfg_err`=0, `ccff_tail`=0.
- Shift 1,1,0, then commit, with `in`=4'b0100 → `act`=3'b110, `out`=1, `cfg_valid`=1; toggling `in[2]` alone toggles `out`.
- Shift 1,0 only, then commit → `cfg_err`=1, `act` unchanged, `out` still equals the previous selection.
- Shift 1,0,1 and commit in the same cycle as a fourth shift of bit 0 → `act`=3'b101, `cnt`=1, `out`=`in[1]`.
- Shift 0,1,1 and commit → the mux is disabled and `out`=1 regardless of `in`. After three further shifts of 1,0,0, `ccff_tail` has emitted 0,1,1.
- With `MUX_TREE_CCFF_PARITY_EN` defined: shift 1,1,0,1 and commit → accepted. Then shift 1,1,0,0 and commit → rejected with `cfg_err`=1. Finally assert `pReset_n` low mid-shift → all outputs return to their reset values.
